mem_responder: RTL and testbench

Multicycle memory responder: the memory-side end of the CPU's fetch/load/store interface. The control FSM issues requests during the instruction-fetch (IF), load (MEM_LW) and store (MEM_SW) states; this block accepts one request at a time, waits a fixed configurable latency, commits stores, and returns read data with a single-cycle response pulse. It sits between the multicycle CPU datapath and a unified word-addressed instruction/data array.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_resp_ram.sv | 28 ++
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_resp_ram.sv
// Unified word-addressed instruction/data array, single port.
// Latency: write on the rising edge, read is combinational on addr.
// Backpressure: none; the owner serialises accesses.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Array contents are never reset; only an explicit write changes a word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU; optional misalignment check under MEM_RESP_MISALIGN_CHECK_EN.
// Latency: response pulse LATENCY cycles after acceptance; one request per LATENCY+1 cycles.
// Backpressure: req_ready low while busy (requests then ignored); no backpressure on the response.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              lat_we;
  logic              lat_err;
  logic [AW-1:0]     lat_idx;
  logic [WORD_W-1:0] lat_wdata;

  logic              accept;
  logic              req_misalign;
  logic              commit;
  logic              ram_we;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign req_idx = req_addr[BYTE_OFF_W +: AW];
  assign accept  = (state == IDLE) && req_valid;

  // Upper address bits wrap away; the byte offset only matters with the check enabled.
  assign unused_addr_bits = ^{req_addr[31:AW+BYTE_OFF_W], req_addr[BYTE_OFF_W-1:0]};

`ifdef MEM_RESP_MISALIGN_CHECK_EN
  assign req_misalign = |req_addr[BYTE_OFF_W-1:0];
`else
  assign req_misalign = 1'b0;
`endif

  // Next-state, counter and output decode. The write happens on the edge that
  // enters RESP; with LATENCY=1 that is the acceptance edge itself, so the
  // live request fields feed the array instead of the latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    ram_addr  = lat_idx;
    ram_wdata = lat_wdata;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = req_we && !req_misalign;
            ram_addr  = req_idx;
            ram_wdata = req_wdata;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          commit    = lat_we && !lat_err;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = lat_err;
        if (!lat_we && !lat_err) begin
          rsp_rdata = ram_rdata;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset on the commit edge abandons the store.
  assign ram_we = commit && rst_n;

  // State, counter and request latches; fields are captured only at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_err   <= req_misalign;
        lat_idx   <= req_idx;
        lat_wdata <= req_wdata;
      end
    end
  end

  mem_resp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1.
// Expected data comes from a per-instance word-array model updated on store responses.
// Responses are checked cycle by cycle against the acceptance cycle.
module tb_mem_responder;

`ifdef MEM_RESP_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] model [2][1024];
  bit          known [2][1024];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (inst %0d): observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, "_ready"}, d, 32'(req_ready[d]), 32'd1);
    check({tag, "_valid"}, d, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_rdata"}, d, rsp_rdata[d], 32'd0);
    check({tag, "_err"},   d, 32'(rsp_err[d]),   32'd0);
  endtask

  // One request from an IDLE negedge; returns at the negedge after the response.
  // chg keeps req_valid high and switches to a load of 0x20 while busy.
  task automatic txn(input int d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit chg);
    int          lat;
    int          idx;
    bit          mis;
    bit          chk_rd;
    logic [31:0] exp_rd;
    lat    = (d == 0) ? 2 : 1;
    idx    = int'(addr[11:2]);
    mis    = MIS_EN && (addr[1:0] != 2'b00);
    chk_rd = we || mis || known[d][idx];
    exp_rd = (we || mis) ? 32'd0 : model[d][idx];
    check("accept_ready", d, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(negedge clk);
    if (chg) begin
      req_addr[d] = 32'h20;
      req_we[d]   = 1'b0;
    end else begin
      req_valid[d] = 1'b0;
    end
    for (int k = 1; k < lat; k++) begin
      check("wait_valid", d, 32'(rsp_valid[d]), 32'd0);
      check("wait_ready", d, 32'(req_ready[d]), 32'd0);
      check("wait_rdata", d, rsp_rdata[d], 32'd0);
      @(negedge clk);
    end
    check("rsp_valid", d, 32'(rsp_valid[d]), 32'd1);
    check("rsp_ready", d, 32'(req_ready[d]), 32'd0);
    check("rsp_err",   d, 32'(rsp_err[d]),   32'(mis));
    if (chk_rd) check("rsp_rdata", d, rsp_rdata[d], exp_rd);
    if (we && !mis) begin
      model[d][idx] = wdata;
      known[d][idx] = 1'b1;
    end
    req_valid[d] = 1'b0;
    @(negedge clk);
    check_idle("after_rsp", d);
  endtask

  initial begin
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    check_idle("in_reset", 0);
    check_idle("in_reset", 1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 0);
    check_idle("post_reset", 1);

    // Store then load back at LATENCY=2.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

    // Held request with a changed address is ignored while busy.
    txn(0, 1'b1, 32'h20, 32'h2020_2020, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b1);
    @(negedge clk);
    check_idle("no_queue", 0);

    // Wrap-around: 0x1000 aliases word 0.
    txn(0, 1'b1, 32'h1000, 32'h12345678, 1'b0);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("wrap_model", 0, model[0][0], 32'h12345678);

    // Reset during WAIT cancels the store on its commit edge.
    txn(0, 1'b1, 32'h40, 32'h0, 1'b0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'hA5A5A5A5;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0]     = 1'b0;
    check("abort_wait_valid", 0, 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    check("abort_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
    check("abort_ready", 0, 32'(req_ready[0]), 32'd1);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_idle("abort_idle", 0);
    txn(0, 1'b0, 32'h40, 32'h0, 1'b0);

    // Misaligned store: error and suppressed with the check, plain write without.
    txn(0, 1'b1, 32'h42, 32'h99999999, 1'b0);
    txn(0, 1'b0, 32'h40, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h43, 32'h0, 1'b0);

    // LATENCY=1 back-to-back loads: ready and valid alternate.
    txn(1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0);
    txn(1, 1'b1, 32'hC, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 6; i++) txn(1, 1'b0, (i % 2 == 0) ? 32'h8 : 32'hC, 32'h0, 1'b0);

    // Randomized traffic on both instances over a few aliased words.
    for (int i = 0; i < 80; i++) begin
      int d;
      d = i % 2;
      a = ($urandom << 12) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      txn(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
